// File: rtl/npc_pkg.sv
// Shared types and defaults for the memory arbiter: FSM states, transaction
// owner encoding, default bus widths and a counter-width helper.
package npc_pkg;

    localparam int NPC_ADDR_W = 32;
    localparam int NPC_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    // Bits needed to hold the values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// WAIT-state watchdog. The count is 0 on the first WAIT cycle and advances
// once per enabled cycle; expired flags the cycle whose increment would make
// the count reach TIMEOUT, so the error response is registered on that edge.
// TIMEOUT must be at least 1.
module arb_timeout_cnt
    import npc_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise advance while enabled and stop at TIMEOUT.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter in front of a single-outstanding memory
// port. LSU has priority; an IFU starved for STARVE_LIMIT consecutive LSU
// grants is forced through. One transaction is in flight at a time.
module mem_arbiter
    import npc_pkg::*;
#(
    parameter int ADDR_W       = NPC_ADDR_W,
    parameter int DATA_W       = NPC_DATA_W,
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_resp_data,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_resp_data,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic                busy
);

    localparam int MASK_W   = DATA_W / 8;
    localparam int STARVE_W = cnt_width(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_e            state_q, state_d;
    owner_e                owner_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  wen_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [MASK_W-1:0]     wmask_q;
    logic [STARVE_W-1:0]   starve_q;
    logic                  ifu_resp_valid_q, lsu_resp_valid_q;
    logic                  ifu_resp_err_q, lsu_resp_err_q;
    logic [DATA_W-1:0]     ifu_resp_data_q, lsu_resp_data_q;

    logic grant_ifu, grant_lsu;
    logic ifu_accept, lsu_accept;
    logic to_enable, to_clear, to_expired;
    logic resp_fire;

    // Arbitration: LSU first, unless the IFU has hit the starvation limit.
    always_comb begin
        grant_ifu = ifu_req_valid && (!lsu_req_valid || (starve_q == STARVE_MAX));
        grant_lsu = lsu_req_valid && !grant_ifu;
    end

    assign ifu_accept = ifu_req_valid && ifu_req_ready;
    assign lsu_accept = lsu_req_valid && lsu_req_ready;
    assign resp_fire  = (state_q == ST_WAIT) && (mem_resp_valid || to_expired);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (ifu_accept || lsu_accept) state_d = ST_REQ;
            ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
            ST_WAIT: if (mem_resp_valid || to_expired) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE for the granted side, request in REQ, watchdog in WAIT.
    always_comb begin
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        busy          = 1'b1;
        to_enable     = 1'b0;
        to_clear      = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                busy          = 1'b0;
            end
            ST_REQ:  mem_req_valid = 1'b1;
            ST_WAIT: begin
                to_enable = 1'b1;
                to_clear  = 1'b0;
            end
            default: ;
        endcase
    end

    // Capture the accepted request; a fetch is always a full read with no store data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (ifu_accept) begin
            owner_q <= OWN_IFU;
            addr_q  <= ifu_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (lsu_accept) begin
            owner_q <= OWN_LSU;
            addr_q  <= lsu_addr;
            wen_q   <= lsu_wen;
            wdata_q <= lsu_wdata;
            wmask_q <= lsu_wmask;
        end
    end

    // Starvation count: LSU wins over a waiting IFU bump it, any IFU grant clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else if (ifu_accept) begin
            starve_q <= '0;
        end else if (lsu_accept && ifu_req_valid && (starve_q != STARVE_MAX)) begin
            starve_q <= starve_q + STARVE_W'(1);
        end
    end

    // Response pulse to the owner; data holds between pulses, err only accompanies a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_resp_err_q   <= 1'b0;
            lsu_resp_err_q   <= 1'b0;
            ifu_resp_data_q  <= '0;
            lsu_resp_data_q  <= '0;
        end else begin
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_resp_err_q   <= 1'b0;
            lsu_resp_err_q   <= 1'b0;
            if (resp_fire) begin
                if (owner_q == OWN_IFU) begin
                    ifu_resp_valid_q <= 1'b1;
                    ifu_resp_err_q   <= !mem_resp_valid;
                    ifu_resp_data_q  <= mem_resp_valid ? mem_resp_data : '0;
                end else begin
                    lsu_resp_valid_q <= 1'b1;
                    lsu_resp_err_q   <= !mem_resp_valid;
                    lsu_resp_data_q  <= mem_resp_valid ? mem_resp_data : '0;
                end
            end
        end
    end

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .enable  (to_enable),
        .clear   (to_clear),
        .expired (to_expired)
    );

    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign ifu_resp_data  = ifu_resp_data_q;
    assign ifu_resp_err   = ifu_resp_err_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign lsu_resp_data  = lsu_resp_data_q;
    assign lsu_resp_err   = lsu_resp_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a random
// phase, all compared against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int TO = 8;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_resp_data;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_resp_data;
    logic [MW-1:0] lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_resp_data;
    logic [MW-1:0] mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int base     = 0;

    // Reference model: phase 0 = no transaction, 1 = request issued, 2 = awaiting data.
    int            m_phase, m_waited, m_starve;
    bit            m_lsu;
    logic [AW-1:0] m_addr;
    logic          m_wen;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;
    logic          e_iv, e_ie, e_lv, e_le;
    logic [DW-1:0] e_id, e_ld;

    // Observations of the DUT for the directed timing checks.
    int            g_own[$];
    int            g_cyc[$];
    logic [AW-1:0] pay_addr_q[$];
    logic [DW-1:0] pay_wdata_q[$];
    logic [MW:0]   pay_ctl_q[$];
    int            ifu_rsp_cnt, ifu_rsp_first, ifu_rsp_last;
    int            lsu_rsp_cnt, lsu_rsp_first;
    logic [DW-1:0] ifu_rsp_dat, lsu_rsp_dat;
    logic          ifu_rsp_er, lsu_rsp_er;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        m_phase = 0; m_waited = 0; m_starve = 0; m_lsu = 1'b0;
        m_addr = '0; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
        e_iv = 1'b0; e_ie = 1'b0; e_id = '0;
        e_lv = 1'b0; e_le = 1'b0; e_ld = '0;
    endtask

    task automatic clear_obs();
        g_own.delete(); g_cyc.delete();
        pay_addr_q.delete(); pay_wdata_q.delete(); pay_ctl_q.delete();
        ifu_rsp_cnt = 0; ifu_rsp_first = -100; ifu_rsp_last = -100;
        lsu_rsp_cnt = 0; lsu_rsp_first = -100;
        base = cyc;
    endtask

    function automatic int own_at(input int i);
        return (i < g_own.size()) ? g_own[i] : -1;
    endfunction

    function automatic int gcyc_at(input int i);
        return (i < g_cyc.size()) ? g_cyc[i] - base : -1;
    endfunction

    // One clock cycle: drive just after the falling edge, check, then advance the model at the rising edge.
    task automatic step(input logic iv, input logic [AW-1:0] ia,
                        input logic lv, input logic [AW-1:0] la, input logic lw,
                        input logic [DW-1:0] lwd, input logic [MW-1:0] lwm,
                        input logic mr, input logic mv, input logic [DW-1:0] md);
        logic g_ifu, g_lsu;
        ifu_req_valid = iv; ifu_addr = ia;
        lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lwm;
        mem_req_ready = mr; mem_resp_valid = mv; mem_resp_data = md;
        #1;
        g_ifu = (m_phase == 0) && iv && (!lv || (m_starve == SL));
        g_lsu = (m_phase == 0) && lv && !g_ifu;
        check("ifu_req_ready", ifu_req_ready, g_ifu);
        check("lsu_req_ready", lsu_req_ready, g_lsu);
        check("busy", busy, m_phase != 0);
        check("mem_req_valid", mem_req_valid, m_phase == 1);
        if (m_phase == 1) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_wen", mem_wen, m_wen);
            check("mem_wdata", mem_wdata, m_wdata);
            check("mem_wmask", mem_wmask, m_wmask);
        end
        check("ifu_resp_valid", ifu_resp_valid, e_iv);
        check("ifu_resp_data", ifu_resp_data, e_id);
        check("ifu_resp_err", ifu_resp_err, e_ie);
        check("lsu_resp_valid", lsu_resp_valid, e_lv);
        check("lsu_resp_data", lsu_resp_data, e_ld);
        check("lsu_resp_err", lsu_resp_err, e_le);
        if (ifu_req_valid && ifu_req_ready) begin g_own.push_back(0); g_cyc.push_back(cyc); end
        if (lsu_req_valid && lsu_req_ready) begin g_own.push_back(1); g_cyc.push_back(cyc); end
        if (mem_req_valid) begin
            pay_addr_q.push_back(mem_addr);
            pay_wdata_q.push_back(mem_wdata);
            pay_ctl_q.push_back({mem_wen, mem_wmask});
        end
        if (ifu_resp_valid) begin
            if (ifu_rsp_cnt == 0) ifu_rsp_first = cyc - base;
            ifu_rsp_last = cyc - base; ifu_rsp_cnt++;
            ifu_rsp_dat = ifu_resp_data; ifu_rsp_er = ifu_resp_err;
        end
        if (lsu_resp_valid) begin
            if (lsu_rsp_cnt == 0) lsu_rsp_first = cyc - base;
            lsu_rsp_cnt++;
            lsu_rsp_dat = lsu_resp_data; lsu_rsp_er = lsu_resp_err;
        end
        @(posedge clk);
        e_iv = 1'b0; e_ie = 1'b0; e_lv = 1'b0; e_le = 1'b0;
        case (m_phase)
            0: begin
                if (g_ifu) begin
                    m_lsu = 1'b0; m_addr = ia; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
                    m_starve = 0; m_phase = 1;
                end else if (g_lsu) begin
                    m_lsu = 1'b1; m_addr = la; m_wen = lw; m_wdata = lwd; m_wmask = lwm;
                    if (iv && m_starve < SL) m_starve++;
                    m_phase = 1;
                end
            end
            1: if (mr) begin m_phase = 2; m_waited = 0; end
            default: begin
                m_waited++;
                if (mv || m_waited == TO) begin
                    if (m_lsu) begin e_lv = 1'b1; e_le = !mv; e_ld = mv ? md : '0; end
                    else       begin e_iv = 1'b1; e_ie = !mv; e_id = mv ? md : '0; end
                    m_phase = 0;
                end
            end
        endcase
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_step(input logic mr, input logic mv, input logic [DW-1:0] md);
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, mr, mv, md);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b0;
        #1;
        check("rstw_busy", busy, 1'b0);
        check("rstw_mem_req_valid", mem_req_valid, 1'b0);
        check("rstw_ifu_resp_valid", ifu_resp_valid, 1'b0);
        check("rstw_lsu_resp_valid", lsu_resp_valid, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_ifu_resp_valid", ifu_resp_valid, 1'b0);
        check("rst_lsu_resp_valid", lsu_resp_valid, 1'b0);
        check("rst_resp_err", {ifu_resp_err, lsu_resp_err}, 2'b00);
        check("rst_resp_data", {ifu_resp_data, lsu_resp_data}, 64'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Simultaneous requests: LSU first, answered at cycle 3, IFU granted at cycle 3.
        clear_obs();
        step(1'b1, 32'h8000_0000, 1'b1, 32'h8000_1000, 1'b0, '0, '0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        for (int k = 1; k < 4; k++)
            step(1'b1, 32'h8000_0000, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        for (int k = 4; k < 7; k++) idle_step(1'b1, 1'b1, 32'hCAFE_F00D);
        check("sim_first_owner_lsu", own_at(0), 1);
        check("sim_lsu_grant_cyc", gcyc_at(0), 0);
        check("sim_lsu_resp_cyc", lsu_rsp_first, 3);
        check("sim_lsu_resp_data", lsu_rsp_dat, 32'hDEAD_BEEF);
        check("sim_second_owner_ifu", own_at(1), 0);
        check("sim_ifu_grant_cyc", gcyc_at(1), 3);
        check("sim_ifu_resp_cyc", ifu_rsp_first, 6);

        // Starvation: four LSU grants, then the IFU, then the pattern repeats from zero.
        clear_obs();
        for (int k = 0; k < 30; k++)
            step(1'b1, 32'h8000_0040 + 32'(k), 1'b1, 32'h8000_2000 + 32'(k), 1'b0, '0, '0,
                 1'b1, 1'b1, $urandom);
        check("stv_grant_count", g_own.size(), 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("stv_owner_%0d", i), own_at(i), (i % 5 == 4) ? 0 : 1);

        // Store with memory ready delayed three cycles: payload constant over four REQ cycles.
        clear_obs();
        step(1'b0, '0, 1'b1, 32'h8000_3000, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b0, '0);
        for (int k = 1; k < 4; k++) idle_step(1'b0, 1'b0, '0);
        idle_step(1'b1, 1'b0, '0);
        idle_step(1'b0, 1'b1, 32'h0000_00A5);
        idle_step(1'b0, 1'b0, '0);
        check("st_req_cycles", pay_addr_q.size(), 4);
        for (int i = 0; i < pay_addr_q.size(); i++) begin
            check("st_addr", pay_addr_q[i], 32'h8000_3000);
            check("st_wdata", pay_wdata_q[i], 32'h1234_5678);
            check("st_wen_wmask", pay_ctl_q[i], 5'h1F);
        end
        check("st_resp_cnt", lsu_rsp_cnt, 1);
        check("st_resp_err", lsu_rsp_er, 1'b0);

        // Timeout: WAIT entered at cycle 2, error at cycle 2+TO, late data at +2 ignored.
        clear_obs();
        step(1'b1, 32'h8000_0100, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        for (int k = 1; k < 16; k++) idle_step(1'b1, k == 2 + TO + 2, 32'h7777_7777);
        check("to_resp_cnt", ifu_rsp_cnt, 1);
        check("to_resp_cyc", ifu_rsp_first, 2 + TO);
        check("to_resp_err", ifu_rsp_er, 1'b1);
        check("to_resp_data", ifu_rsp_dat, 32'h0);
        check("to_lsu_quiet", lsu_rsp_cnt, 0);

        // Reset while waiting: transaction abandoned, late data dropped, grant on first edge.
        step(1'b1, 32'h8000_0200, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
        idle_step(1'b1, 1'b0, '0);
        idle_step(1'b0, 1'b0, '0);
        pulse_reset();
        clear_obs();
        step(1'b0, '0, 1'b1, 32'h8000_4000, 1'b0, '0, '0, 1'b1, 1'b1, 32'hBAD0_BAD0);
        idle_step(1'b1, 1'b1, 32'hBAD0_BAD0);
        idle_step(1'b0, 1'b1, 32'h0000_0055);
        idle_step(1'b0, 1'b0, '0);
        check("rw_first_grant_cyc", gcyc_at(0), 0);
        check("rw_first_grant_lsu", own_at(0), 1);
        check("rw_no_ifu_resp", ifu_rsp_cnt, 0);
        check("rw_lsu_resp_cnt", lsu_rsp_cnt, 1);
        check("rw_lsu_resp_data", lsu_rsp_dat, 32'h0000_0055);

        // Back-to-back fetches: accepts at 0 and 3, responses at 3 and 6.
        clear_obs();
        step(1'b1, 32'h8000_0000, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h1111_0000);
        for (int k = 1; k < 4; k++)
            step(1'b1, 32'h8000_0004, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h1111_0004);
        for (int k = 4; k < 7; k++) idle_step(1'b1, 1'b1, 32'h2222_0000);
        check("b2b_grant0_cyc", gcyc_at(0), 0);
        check("b2b_grant1_cyc", gcyc_at(1), 3);
        check("b2b_addr0", pay_addr_q.size() > 0 ? pay_addr_q[0] : 32'hx, 32'h8000_0000);
        check("b2b_addr1", pay_addr_q.size() > 1 ? pay_addr_q[1] : 32'hx, 32'h8000_0004);
        check("b2b_resp_cnt", ifu_rsp_cnt, 2);
        check("b2b_resp0_cyc", ifu_rsp_first, 3);
        check("b2b_resp1_cyc", ifu_rsp_last, 6);

        // Random traffic against the model, including occasional timeouts.
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom,
                 $urandom_range(0, 1), $urandom, MW'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom);
        for (int k = 0; k < 12; k++) idle_step(1'b1, 1'b1, $urandom);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
